// File: rtl/atm_core_if.sv
// Bus bundle for atm_core: keypad/amount strobes in, result pulses and balance out.
// Strobes are valid-only (no ready): the core consumes a strobe in the cycle it is
// high only when its FSM is in the state that owns it, otherwise it is dropped.
interface atm_core_if;
  logic        tarjeta_recibida;
  logic        tipo_trans;
  logic        digito_stb;
  logic [3:0]  digito;
  logic        monto_stb;
  logic [31:0] monto;
  logic        balance_actualizado;
  logic        entregar_dinero;
  logic        pin_incorrecto;
  logic        advertencia;
  logic        bloqueo;
  logic        fondos_insuficientes;
  logic [63:0] balance;

  modport master (
    output tarjeta_recibida, tipo_trans, digito_stb, digito, monto_stb, monto,
    input  balance_actualizado, entregar_dinero, pin_incorrecto, advertencia,
           bloqueo, fondos_insuficientes, balance
  );

  modport slave (
    input  tarjeta_recibida, tipo_trans, digito_stb, digito, monto_stb, monto,
    output balance_actualizado, entregar_dinero, pin_incorrecto, advertencia,
           bloqueo, fondos_insuficientes, balance
  );
endinterface

// File: rtl/atm_core.sv
// ATM controller: card insert, 4-digit PIN check with 3-strike lock, deposit/withdraw.
// All outputs are registered; dbg_state exposes the FSM state.
module atm_core #(
  parameter logic [15:0] PIN          = 16'h4756,
  parameter logic [63:0] BALANCE_INIT = 64'd5000
) (
  input  logic              clk,
  input  logic              rst,
  atm_core_if.slave         bus,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    ESPERANDO_TARJETA = 3'd0,
    VERIFICAR_PIN     = 3'd1,
    COMPARAR          = 3'd2,
    ESPERANDO_MONTO   = 3'd3,
    BLOQUEO           = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pin_q, pin_d;
  logic [1:0]  dig_cnt_q, dig_cnt_d;
  logic [1:0]  att_cnt_q, att_cnt_d;
  logic [63:0] balance_q, balance_d;
  logic        bal_act_q, bal_act_d;
  logic        entregar_q, entregar_d;
  logic        pin_inc_q, pin_inc_d;
  logic        advert_q, advert_d;
  logic        bloqueo_q, bloqueo_d;
  logic        fondos_q, fondos_d;

  logic [64:0] sum;
  logic [63:0] monto_ext;

  assign monto_ext = {32'd0, bus.monto};
  assign sum       = {1'b0, balance_q} + {1'b0, monto_ext};

  always_comb begin
    state_d    = state_q;
    pin_d      = pin_q;
    dig_cnt_d  = dig_cnt_q;
    att_cnt_d  = att_cnt_q;
    balance_d  = balance_q;
    bal_act_d  = 1'b0;
    entregar_d = 1'b0;
    pin_inc_d  = 1'b0;
    fondos_d   = 1'b0;
    advert_d   = advert_q;
    bloqueo_d  = bloqueo_q;

    unique case (state_q)
      ESPERANDO_TARJETA: begin
        if (bus.tarjeta_recibida) begin
          state_d   = VERIFICAR_PIN;
          dig_cnt_d = 2'd0;
        end
      end
      VERIFICAR_PIN: begin
        if (bus.digito_stb) begin
          pin_d     = {pin_q[11:0], bus.digito};
          dig_cnt_d = dig_cnt_q + 2'd1;
          if (dig_cnt_q == 2'd3) state_d = COMPARAR;
        end
      end
      COMPARAR: begin
        dig_cnt_d = 2'd0;
        if (pin_q == PIN) begin
          state_d   = ESPERANDO_MONTO;
          att_cnt_d = 2'd0;
          advert_d  = 1'b0;
        end else begin
          pin_inc_d = 1'b1;
          att_cnt_d = att_cnt_q + 2'd1;
          // Third consecutive miss locks the card; the warning gives way to the lock.
          if (att_cnt_q == 2'd2) begin
            state_d   = BLOQUEO;
            bloqueo_d = 1'b1;
            advert_d  = 1'b0;
          end else begin
            state_d = VERIFICAR_PIN;
            if (att_cnt_q == 2'd1) advert_d = 1'b1;
          end
        end
      end
      ESPERANDO_MONTO: begin
        if (bus.monto_stb) begin
          state_d = ESPERANDO_TARJETA;
          if (!bus.tipo_trans) begin
            balance_d = sum[64] ? '1 : sum[63:0];
            bal_act_d = 1'b1;
          end else if (monto_ext <= balance_q) begin
            balance_d  = balance_q - monto_ext;
            bal_act_d  = 1'b1;
            entregar_d = 1'b1;
          end else begin
            fondos_d = 1'b1;
          end
        end
      end
      BLOQUEO: begin
        bloqueo_d = 1'b1;
      end
      default: state_d = ESPERANDO_TARJETA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ESPERANDO_TARJETA;
      pin_q      <= 16'd0;
      dig_cnt_q  <= 2'd0;
      att_cnt_q  <= 2'd0;
      balance_q  <= BALANCE_INIT;
      bal_act_q  <= 1'b0;
      entregar_q <= 1'b0;
      pin_inc_q  <= 1'b0;
      advert_q   <= 1'b0;
      bloqueo_q  <= 1'b0;
      fondos_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pin_q      <= pin_d;
      dig_cnt_q  <= dig_cnt_d;
      att_cnt_q  <= att_cnt_d;
      balance_q  <= balance_d;
      bal_act_q  <= bal_act_d;
      entregar_q <= entregar_d;
      pin_inc_q  <= pin_inc_d;
      advert_q   <= advert_d;
      bloqueo_q  <= bloqueo_d;
      fondos_q   <= fondos_d;
    end
  end

  assign bus.balance_actualizado  = bal_act_q;
  assign bus.entregar_dinero      = entregar_q;
  assign bus.pin_incorrecto       = pin_inc_q;
  assign bus.advertencia          = advert_q;
  assign bus.bloqueo              = bloqueo_q;
  assign bus.fondos_insuficientes = fondos_q;
  assign bus.balance              = balance_q;
  assign dbg_state                = state_q;

endmodule

// File: tb/tb_atm_core.sv
// Directed bench for atm_core: card/PIN/transaction scenarios with hand-computed results.
module tb_atm_core;
  localparam logic [2:0] S_TARJ = 3'd0, S_VERIF = 3'd1, S_COMP = 3'd2,
                         S_MONTO = 3'd3, S_BLOQ = 3'd4;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
  int         n_checks;
  int         n_fail;

  atm_core_if bus ();

  atm_core dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic insert_card();
    bus.tarjeta_recibida = 1'b1;
    step();
    bus.tarjeta_recibida = 1'b0;
  endtask

  // Drives four digits, first digit from [15:12]; leaves FSM in COMPARAR.
  task automatic enter_pin(input logic [15:0] p);
    for (int i = 3; i >= 0; i--) begin
      bus.digito_stb = 1'b1;
      bus.digito     = p[i*4 +: 4];
      step();
    end
    bus.digito_stb = 1'b0;
  endtask

  task automatic txn(input logic tipo, input logic [31:0] amt);
    bus.monto_stb  = 1'b1;
    bus.tipo_trans = tipo;
    bus.monto      = amt;
    step();
    bus.monto_stb  = 1'b0;
  endtask

  task automatic check_pulses(input string tag, input logic ba, input logic ed,
                              input logic pi, input logic fi);
    check({tag, ".bal_act"}, 64'(bus.balance_actualizado), 64'(ba));
    check({tag, ".entregar"}, 64'(bus.entregar_dinero), 64'(ed));
    check({tag, ".pin_inc"}, 64'(bus.pin_incorrecto), 64'(pi));
    check({tag, ".fondos"}, 64'(bus.fondos_insuficientes), 64'(fi));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.tarjeta_recibida = 1'b0;
    bus.tipo_trans       = 1'b0;
    bus.digito_stb       = 1'b0;
    bus.digito           = 4'd0;
    bus.monto_stb        = 1'b0;
    bus.monto            = 32'd0;
    do_reset();

    check("rst.state", 64'(dbg_state), 64'(S_TARJ));
    check("rst.balance", bus.balance, 64'd5000);
    check_pulses("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst.advert", 64'(bus.advertencia), 64'd0);
    check("rst.bloqueo", 64'(bus.bloqueo), 64'd0);

    // Strobes while waiting for a card are ignored.
    bus.monto_stb = 1'b1; bus.tipo_trans = 1'b0; bus.monto = 32'd77;
    bus.digito_stb = 1'b1; bus.digito = 4'd4;
    step();
    bus.monto_stb = 1'b0; bus.digito_stb = 1'b0;
    check("idle.state", 64'(dbg_state), 64'(S_TARJ));
    check("idle.balance", bus.balance, 64'd5000);

    // Deposit 10000 with correct PIN.
    insert_card();
    check("dep.state_verif", 64'(dbg_state), 64'(S_VERIF));
    enter_pin(16'h4756);
    check("dep.state_comp", 64'(dbg_state), 64'(S_COMP));
    step();
    check("dep.state_monto", 64'(dbg_state), 64'(S_MONTO));
    check("dep.pin_inc", 64'(bus.pin_incorrecto), 64'd0);
    txn(1'b0, 32'd10000);
    check_pulses("dep", 1'b1, 1'b0, 1'b0, 1'b0);
    check("dep.balance", bus.balance, 64'd15000);
    check("dep.state_end", 64'(dbg_state), 64'(S_TARJ));
    step();
    check("dep.pulse_len", 64'(bus.balance_actualizado), 64'd0);

    // Two wrong PINs, then correct; withdraw 10000.
    insert_card();
    enter_pin(16'h4757);
    step();
    check_pulses("wr1", 1'b0, 1'b0, 1'b1, 1'b0);
    check("wr1.advert", 64'(bus.advertencia), 64'd0);
    check("wr1.state", 64'(dbg_state), 64'(S_VERIF));
    step();
    check("wr1.pulse_len", 64'(bus.pin_incorrecto), 64'd0);
    check("wr1.state_hold", 64'(dbg_state), 64'(S_VERIF));
    enter_pin(16'h4757);
    step();
    check("wr2.pin_inc", 64'(bus.pin_incorrecto), 64'd1);
    check("wr2.advert", 64'(bus.advertencia), 64'd1);
    check("wr2.state", 64'(dbg_state), 64'(S_VERIF));
    enter_pin(16'h4756);
    check("ok3.advert_held", 64'(bus.advertencia), 64'd1);
    step();
    check("ok3.advert", 64'(bus.advertencia), 64'd0);
    check("ok3.state", 64'(dbg_state), 64'(S_MONTO));
    txn(1'b1, 32'd10000);
    check_pulses("wd1", 1'b1, 1'b1, 1'b0, 1'b0);
    check("wd1.balance", bus.balance, 64'd5000);

    // Insufficient funds.
    insert_card();
    enter_pin(16'h4756);
    step();
    txn(1'b1, 32'd10000);
    check_pulses("nsf", 1'b0, 1'b0, 1'b0, 1'b1);
    check("nsf.balance", bus.balance, 64'd5000);
    check("nsf.state", 64'(dbg_state), 64'(S_TARJ));
    step();
    check("nsf.pulse_len", 64'(bus.fondos_insuficientes), 64'd0);

    // Withdraw 1000.
    insert_card();
    enter_pin(16'h4756);
    step();
    txn(1'b1, 32'd1000);
    check_pulses("wd2", 1'b1, 1'b1, 1'b0, 1'b0);
    check("wd2.balance", bus.balance, 64'd4000);

    // Withdraw exactly the balance (boundary monto == balance).
    insert_card();
    enter_pin(16'h4756);
    step();
    txn(1'b1, 32'd4000);
    check_pulses("wd_eq", 1'b1, 1'b1, 1'b0, 1'b0);
    check("wd_eq.balance", bus.balance, 64'd0);

    // Reset mid-PIN; fresh four digits required afterwards.
    insert_card();
    bus.digito_stb = 1'b1; bus.digito = 4'd4; step();
    bus.digito = 4'd7; step();
    bus.digito_stb = 1'b0;
    do_reset();
    check("midrst.state", 64'(dbg_state), 64'(S_TARJ));
    check("midrst.balance", bus.balance, 64'd5000);
    bus.digito_stb = 1'b1; bus.digito = 4'd5; step();
    bus.digito_stb = 1'b0;
    check("midrst.dig_ignored", 64'(dbg_state), 64'(S_TARJ));
    insert_card();
    bus.digito_stb = 1'b1; bus.digito = 4'd4; step();
    bus.digito = 4'd7; step();
    bus.digito_stb = 1'b0;
    check("midrst.two_digits", 64'(dbg_state), 64'(S_VERIF));
    enter_pin(16'h5656);
    step();
    check("midrst.fresh_pin", 64'(dbg_state), 64'(S_MONTO));
    check("midrst.pin_inc", 64'(bus.pin_incorrecto), 64'd0);

    // Zero deposit is a valid transaction.
    txn(1'b0, 32'd0);
    check_pulses("dep0", 1'b1, 1'b0, 1'b0, 1'b0);
    check("dep0.balance", bus.balance, 64'd5000);

    // Three wrong PINs lock the card; digit 0xA can only mismatch.
    insert_card();
    enter_pin(16'h475A);
    step();
    check("lk1.pin_inc", 64'(bus.pin_incorrecto), 64'd1);
    enter_pin(16'h1111);
    step();
    check("lk2.advert", 64'(bus.advertencia), 64'd1);
    enter_pin(16'h0000);
    step();
    check("lk3.pin_inc", 64'(bus.pin_incorrecto), 64'd1);
    check("lk3.state", 64'(dbg_state), 64'(S_BLOQ));
    check("lk3.bloqueo", 64'(bus.bloqueo), 64'd1);
    check("lk3.advert", 64'(bus.advertencia), 64'd0);
    insert_card();
    enter_pin(16'h4756);
    step();
    check("lk.hold_state", 64'(dbg_state), 64'(S_BLOQ));
    check("lk.hold_bloqueo", 64'(bus.bloqueo), 64'd1);
    check("lk.hold_pin_inc", 64'(bus.pin_incorrecto), 64'd0);
    do_reset();
    check("lkrst.bloqueo", 64'(bus.bloqueo), 64'd0);
    check("lkrst.state", 64'(dbg_state), 64'(S_TARJ));
    check("lkrst.balance", bus.balance, 64'd5000);

    // Attempt counter cleared by reset: two misses only warn, not lock.
    insert_card();
    enter_pin(16'h0001);
    step();
    enter_pin(16'h0002);
    step();
    check("postrst.state", 64'(dbg_state), 64'(S_VERIF));
    check("postrst.bloqueo", 64'(bus.bloqueo), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/atm_core.md
ATM_CORE -- requirements
Module: atm_core

Interface
REQ-001 Parameter PIN, default 16'h4756, correct PIN as four BCD nibbles, first digit in [15:12].
REQ-002 Parameter BALANCE_INIT, default 64'd5000, account balance after reset.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 tarjeta_recibida  input  1  card-inserted pulse.
REQ-006 tipo_trans  input  1  transaction type: 0 deposit, 1 withdrawal; sampled with monto_stb.
REQ-007 digito_stb  input  1  digito valid strobe, one digit per cycle it is high.
REQ-008 digito  input  4  keypad digit, 0-9.
REQ-009 monto_stb  input  1  monto valid strobe.
REQ-010 monto  input  32  transaction amount, unsigned.
REQ-011 balance_actualizado  output  1  one-cycle pulse: balance changed.
REQ-012 entregar_dinero  output  1  one-cycle pulse: dispense cash.
REQ-013 pin_incorrecto  output  1  one-cycle pulse: 4-digit PIN mismatch.
REQ-014 advertencia  output  1  level: second consecutive wrong PIN.
REQ-015 bloqueo  output  1  level: card locked after third wrong PIN.
REQ-016 fondos_insuficientes  output  1  one-cycle pulse: withdrawal rejected.
REQ-017 balance  output  64  current balance, registered.

Function
REQ-018 States: ESPERANDO_TARJETA, VERIFICAR_PIN, COMPARAR, ESPERANDO_MONTO, BLOQUEO.
REQ-019 All outputs registered; every pulse output high exactly one cycle.
REQ-020 ESPERANDO_TARJETA: tarjeta_recibida=1 -> VERIFICAR_PIN next cycle, digit counter cleared; other inputs ignored.
REQ-021 VERIFICAR_PIN: each cycle with digito_stb=1 shifts digito into 16-bit PIN register (left shift, new nibble in [3:0]) and increments 2-bit digit counter.
REQ-022 On the fourth accepted digit -> COMPARAR next cycle; no timeout while waiting for digits.
REQ-023 COMPARAR (one cycle): match -> ESPERANDO_MONTO, attempt counter cleared, advertencia cleared.
REQ-024 COMPARAR mismatch: pin_incorrecto pulse, attempt counter +1; new count 1 -> VERIFICAR_PIN; 2 -> VERIFICAR_PIN and advertencia set; 3 -> BLOQUEO.
REQ-025 advertencia stays high until PIN match or rst; it is cleared on entry to BLOQUEO.
REQ-026 ESPERANDO_MONTO: monto_stb=1 samples tipo_trans and monto, then -> ESPERANDO_TARJETA next cycle.
REQ-027 Deposit: balance <= balance + zero-extended monto, saturating at 2^64-1; balance_actualizado pulse.
REQ-028 Withdrawal with monto <= balance: balance <= balance - monto; balance_actualizado and entregar_dinero pulse in the same cycle.
REQ-029 Withdrawal with monto > balance: balance unchanged; fondos_insuficientes pulse only.
REQ-030 Result pulses appear the cycle after the monto_stb edge; monto=0 is a valid transaction.
REQ-031 BLOQUEO: bloqueo=1; all inputs ignored; exit only via rst.
REQ-032 tarjeta_recibida outside ESPERANDO_TARJETA, digito_stb outside VERIFICAR_PIN, monto_stb outside ESPERANDO_MONTO are ignored.
REQ-033 digito values 10-15 are accepted as digits and can only cause a mismatch.
REQ-034 Attempt counter persists across cards until PIN match or rst.

Reset
REQ-035 rst=1 at a clock edge: state ESPERANDO_TARJETA, balance=BALANCE_INIT, attempt counter, digit counter, PIN register zero, all outputs 0 except balance.
REQ-036 rst overrides every other input and any state, including mid-PIN entry and BLOQUEO.

Verification
REQ-037 Card, PIN 4-7-5-6, tipo_trans=0, monto=10000 -> balance_actualizado pulse, balance 15000, back to ESPERANDO_TARJETA.
REQ-038 Card, PIN 4-7-5-7 twice, then 4-7-5-6, withdraw 10000 -> two pin_incorrecto pulses, advertencia high after second, cleared on match; balance_actualizado+entregar_dinero, balance 5000.
REQ-039 Card, correct PIN, withdraw 10000 with balance 5000 -> fondos_insuficientes pulse, no entregar_dinero, balance 5000.
REQ-040 Card, correct PIN, withdraw 1000 -> entregar_dinero pulse, balance 4000.
REQ-041 Card, three wrong PINs -> third mismatch enters BLOQUEO, bloqueo=1 held; further tarjeta_recibida ignored; rst -> bloqueo=0, balance 5000.
REQ-042 rst asserted after two PIN digits -> ESPERANDO_TARJETA; next card needs four fresh digits; digito_stb before a card has no effect.
